// File: rtl/comb_m_arb.sv
// Four-requester round-robin arbiter sharing a single evaluator of
// m = (~a&~b&~c)|(~a&b&c)|(a&~b&c); one transaction in flight at a time.
module comb_m_arb #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [11:0]      req_abc,
    output logic [3:0]       gnt,
    output logic             busy,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [1:0]       rsp_id,
    output logic             rsp_m,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr;
    logic [1:0] id_q;
    logic [2:0] abc_q;
    logic [1:0] win;
    logic [1:0] idx;
    logic       win_vld;
    logic [2:0] sel_abc;

    function automatic logic f_m(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (~a & ~b & ~c) | (~a & b & c) | (a & ~b & c);
    endfunction

    // Scan ptr, ptr+1, ... with 2-bit wraparound; first set bit wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        sel_abc = req_abc[2:0];
        case (win)
            2'd0: sel_abc = req_abc[2:0];
            2'd1: sel_abc = req_abc[5:3];
            2'd2: sel_abc = req_abc[8:6];
            2'd3: sel_abc = req_abc[11:9];
            default: sel_abc = req_abc[2:0];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_vld) state_nxt = EVAL;
            EVAL: state_nxt = RESP;
            RESP: if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            rsp_vld  <= 1'b0;
            rsp_m    <= 1'b0;
            rsp_id   <= '0;
            done_cnt <= '0;
            ptr      <= '0;
            abc_q    <= '0;
            id_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        abc_q <= sel_abc;
                        id_q  <= win;
                        gnt   <= 4'b0001 << win;
                    end
                end
                EVAL: begin
                    rsp_m   <= f_m(abc_q);
                    rsp_id  <= id_q;
                    rsp_vld <= 1'b1;
                    gnt     <= '0;
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld  <= 1'b0;
                        ptr      <= id_q + 2'd1;
                        done_cnt <= done_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_comb_m_arb.sv
// Directed bench for comb_m_arb: evaluator truth table, round-robin order,
// backpressure, pointer wrap, mid-transaction reset and counter wrap.
module tb_comb_m_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_abc;
    logic        rsp_rdy;

    logic [3:0]  gnt, gnt2;
    logic        busy, busy2;
    logic        rsp_vld, rsp_vld2;
    logic [1:0]  rsp_id, rsp_id2;
    logic        rsp_m, rsp_m2;
    logic [7:0]  done_cnt;
    logic [1:0]  done_cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    comb_m_arb #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_abc(req_abc), .gnt(gnt),
        .busy(busy), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id),
        .rsp_m(rsp_m), .done_cnt(done_cnt)
    );

    comb_m_arb #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_abc(req_abc), .gnt(gnt2),
        .busy(busy2), .rsp_vld(rsp_vld2), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id2),
        .rsp_m(rsp_m2), .done_cnt(done_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // One full transaction with rsp_rdy high: IDLE -> EVAL -> RESP -> IDLE.
    task automatic txn(input logic [3:0] r, input logic [11:0] abc,
                       input logic [1:0] eid, input logic em);
        req     = r;
        req_abc = abc;
        rsp_rdy = 1'b1;
        step();
        check_eq("gnt_eval", 32'(gnt), 32'(4'b0001 << eid));
        check_eq("busy_eval", 32'(busy), 32'd1);
        check_eq("vld_eval", 32'(rsp_vld), 32'd0);
        req     = 4'b0000;
        req_abc = ~abc;
        step();
        check_eq("vld_resp", 32'(rsp_vld), 32'd1);
        check_eq("id_resp", 32'(rsp_id), 32'(eid));
        check_eq("m_resp", 32'(rsp_m), 32'(em));
        check_eq("gnt_resp", 32'(gnt), 32'd0);
        step();
        exp_cnt++;
        check_eq("vld_idle", 32'(rsp_vld), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("cnt_idle", 32'(done_cnt), 32'(exp_cnt & 8'hFF));
    endtask

    logic [7:0] m_ref;
    logic [1:0] wrap_ref [5];

    initial begin
        m_ref = 8'b0010_1001;
        wrap_ref[0] = 2'd1; wrap_ref[1] = 2'd2; wrap_ref[2] = 2'd3;
        wrap_ref[3] = 2'd0; wrap_ref[4] = 2'd1;
        req = '0; req_abc = '0; rsp_rdy = 1'b0;

        // Reset with requests pending: nothing may be granted.
        req = 4'b1111;
        do_reset();
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_vld", 32'(rsp_vld), 32'd0);
        check_eq("rst_m", 32'(rsp_m), 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        check_eq("rst_cnt", 32'(done_cnt), 32'd0);
        req = '0;

        // Requester 0 alone across all eight operands.
        for (int v = 0; v < 8; v++)
            txn(4'b0001, {9'b0, 3'(v)}, 2'd0, m_ref[v]);
        check_eq("exh_cnt", 32'(done_cnt), 32'd8);

        // Round-robin with all requesting from ptr 0.
        do_reset();
        txn(4'b1111, {3'b101, 3'b011, 3'b000, 3'b111}, 2'd0, 1'b0);
        txn(4'b1111, {3'b101, 3'b011, 3'b000, 3'b111}, 2'd1, 1'b1);
        txn(4'b1111, {3'b101, 3'b011, 3'b000, 3'b111}, 2'd2, 1'b1);
        txn(4'b1111, {3'b101, 3'b011, 3'b000, 3'b111}, 2'd3, 1'b1);
        txn(4'b1111, {3'b101, 3'b011, 3'b000, 3'b111}, 2'd0, 1'b0);

        // Backpressure on requester 2, abc = 011.
        req = 4'b0100;
        req_abc = {3'b000, 3'b011, 3'b000, 3'b000};
        rsp_rdy = 1'b0;
        step();
        check_eq("bp_gnt", 32'(gnt), 32'b0100);
        req = '0;
        req_abc = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_vld", 32'(rsp_vld), 32'd1);
            check_eq("bp_m", 32'(rsp_m), 32'd1);
            check_eq("bp_id", 32'(rsp_id), 32'd2);
            check_eq("bp_cnt", 32'(done_cnt), 32'(exp_cnt));
            step();
        end
        check_eq("bp_vld6", 32'(rsp_vld), 32'd1);
        check_eq("bp_cnt6", 32'(done_cnt), 32'(exp_cnt));
        rsp_rdy = 1'b1;
        step();
        exp_cnt++;
        check_eq("bp_acc_vld", 32'(rsp_vld), 32'd0);
        check_eq("bp_acc_cnt", 32'(done_cnt), 32'(exp_cnt));

        // Pointer skip: serve 1, then req 0011 must wrap to 0.
        txn(4'b0010, 12'o0000, 2'd1, 1'b1);
        txn(4'b0011, 12'o0007, 2'd0, 1'b0);

        // Reset while in EVAL drops the transaction.
        req = 4'b0100;
        req_abc = 12'o0000;
        step();
        check_eq("mr_gnt", 32'(gnt), 32'b0100);
        req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        check_eq("mr_vld", 32'(rsp_vld), 32'd0);
        check_eq("mr_gnt0", 32'(gnt), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_cnt", 32'(done_cnt), 32'd0);
        step();
        check_eq("mr_quiet_vld", 32'(rsp_vld), 32'd0);
        txn(4'b1111, 12'o0000, 2'd0, 1'b1);

        // Narrow counter wraps silently.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            txn(4'b0001, 12'o0005, 2'd0, 1'b1);
            check_eq("wrap_cnt", 32'(done_cnt2), 32'(wrap_ref[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_m_arb.md
COMB_M_ARB -- requirements
Module: comb_m_arb

Interface
REQ-001 Parameter: CNT_W, default 8, width of completed-transaction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request per requester i (bit i); held high until gnt[i] seen.
REQ-005 req_abc  input  12  operand per requester; requester i uses bits [3i+2:3i], order {a,b,c} with a = MSB.
REQ-006 gnt  output  4  one-hot grant, registered, high exactly one cycle per accepted request.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 rsp_vld  output  1  result valid.
REQ-009 rsp_rdy  input  1  consumer accepts result when high with rsp_vld.
REQ-010 rsp_id  output  2  index of requester owning the result.
REQ-011 rsp_m  output  1  evaluated function value.
REQ-012 done_cnt  output  CNT_W  count of responses accepted by consumer.

Function
REQ-013 Block SHALL share one evaluator of m = (~a&~b&~c)|(~a&b&c)|(a&~b&c) among 4 requesters; m=1 only for {a,b,c} = 000, 011, 101.
REQ-014 FSM states SHALL be IDLE, EVAL, RESP; one transaction in flight at a time.
REQ-015 IDLE, req == 0: remain IDLE, no output change.
REQ-016 IDLE, req != 0: winner = first set bit scanning ptr, ptr+1, ... mod 4; at that edge capture winner operand into abc_q, winner into id_q, gnt <= onehot(winner), state <= EVAL.
REQ-017 EVAL (one cycle, gnt high): at edge rsp_m <= f(abc_q), rsp_id <= id_q, rsp_vld <= 1, gnt <= 0, state <= RESP.
REQ-018 RESP: rsp_vld, rsp_m, rsp_id SHALL hold stable while rsp_rdy = 0, with no timeout.
REQ-019 RESP with rsp_rdy = 1: at edge rsp_vld <= 0, ptr <= (id_q + 1) mod 4, done_cnt <= done_cnt + 1, state <= IDLE.
REQ-020 done_cnt SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-021 req and req_abc SHALL be ignored outside IDLE; operand changes after capture do not affect the result.
REQ-022 Minimum cadence SHALL be 3 cycles per transaction (IDLE->EVAL->RESP with rsp_rdy = 1).
REQ-023 Simultaneous requests: exactly one granted per transaction; a requester continuously requesting SHALL be served within 4 transactions (round-robin fairness).
REQ-024 rsp_rdy while rsp_vld = 0 SHALL have no effect.
REQ-025 busy SHALL be combinationally (state != IDLE); all other outputs registered.

Reset
REQ-026 rst = 1 at a rising edge, in any state, SHALL force: state IDLE, gnt 0, rsp_vld 0, rsp_m 0, rsp_id 0, done_cnt 0, ptr 0, abc_q 0, id_q 0.
REQ-027 Transaction in progress at reset SHALL be dropped with no response and no count increment.
REQ-028 While rst = 1, req SHALL be ignored; arbitration resumes on the first edge with rst = 0.

Verification
REQ-029 Exhaustive: requester 0 alone, req_abc[2:0] = 0..7, rsp_rdy = 1 -> rsp_m = 1,0,0,1,0,1,0,0; rsp_id = 0; gnt = 0001 in each EVAL; done_cnt = 8.
REQ-030 Round-robin: req = 1111 held, rsp_rdy = 1 -> grant order 0,1,2,3,0; rsp_id sequence matches; gnt period 3 cycles.
REQ-031 Backpressure: req[2] with abc = 011, rsp_rdy = 0 for 5 cycles then 1 -> rsp_vld high 6 cycles, rsp_m = 1, rsp_id = 2 stable; done_cnt +1 only on accept edge.
REQ-032 Pointer skip: after serving requester 1, req = 0011 -> next grant requester 0 (ptr 2, 3 idle, wrap to 0).
REQ-033 Reset mid-operation: rst asserted in EVAL -> next cycle rsp_vld 0, gnt 0, busy 0, done_cnt 0; next grant from ptr 0.
REQ-034 Counter wrap: CNT_W = 2, 5 accepted responses -> done_cnt sequence 1,2,3,0,1.
